boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_sequencer.sv | 128 ++++++++++++
 tb/tb_boot_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// Byte-stream boot loader: fills program memory, then releases the CPU.
// Define BOOT_CHECKSUM_EN to require a 32-bit sum trailer before release.
module boot_sequencer #(
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        cpu_reset,
    input  logic [29:0] cpu_bus_addr,
    input  logic [31:0] cpu_bus_data_w,
    input  logic [3:0]  cpu_bus_mask_w,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_data_w,
    output logic [3:0]  mem_mask_w,
    output logic        busy,
    output logic        error
);

    localparam logic [4:0] S_HDR   = 5'b00001;
    localparam logic [4:0] S_LOAD  = 5'b00010;
    localparam logic [4:0] S_RUN   = 5'b01000;
    localparam logic [4:0] S_ERROR = 5'b10000;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [4:0] S_CHECK = 5'b00100;
    localparam logic [4:0] S_DONE  = S_CHECK;
`else
    localparam logic [4:0] S_DONE  = S_RUN;
`endif

    logic [4:0]  state;
    logic [4:0]  state_next;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [29:0] n_words;
    logic [29:0] word_idx;
    logic [31:0] wr_data;
    logic        wr_pulse;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum;
`endif

    logic        run;
    logic        take;
    logic        last_byte;
    logic        last_word;
    logic [31:0] word;

    assign run       = (state == S_RUN);
    assign error     = (state == S_ERROR);
    assign in_ready  = !(run || error);
    assign busy      = in_ready;
    assign take      = in_valid && in_ready;
    assign last_byte = take && (byte_cnt == 2'd3);
    // Little-endian: the byte arriving now is the most significant one.
    assign word      = {in_data, shift};
    assign last_word = wr_pulse && (word_idx == n_words - 30'd1);

    assign mem_addr   = run ? cpu_bus_addr   : word_idx;
    assign mem_data_w = run ? cpu_bus_data_w : wr_data;
    assign mem_mask_w = run ? cpu_bus_mask_w : {4{wr_pulse}};

    always_comb begin
        state_next = state;
        unique case (state)
            S_HDR: begin
                if (last_byte) begin
                    if (word > 32'(MAX_WORDS))
                        state_next = S_ERROR;
                    else if (word == 32'd0)
                        state_next = S_DONE;
                    else
                        state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (last_word)
                    state_next = S_DONE;
            end
`ifdef BOOT_CHECKSUM_EN
            S_CHECK: begin
                if (last_byte)
                    state_next = (word == sum) ? S_RUN : S_ERROR;
            end
`endif
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_HDR;
            byte_cnt  <= 2'd0;
            shift     <= 24'd0;
            n_words   <= 30'd0;
            word_idx  <= 30'd0;
            wr_data   <= 32'd0;
            wr_pulse  <= 1'b0;
            cpu_reset <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            sum       <= 32'd0;
`endif
        end else begin
            state     <= state_next;
            cpu_reset <= (state_next != S_RUN);
            wr_pulse  <= 1'b0;
            if (take) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift    <= {in_data, shift[23:8]};
            end
            if (wr_pulse)
                word_idx <= word_idx + 30'd1;
            if (state == S_HDR && last_byte)
                n_words <= word[29:0];
            // Bytes taken during the pulse cycle already belong to the next word.
            if (state == S_LOAD && last_byte) begin
                wr_pulse <= 1'b1;
                wr_data  <= word;
`ifdef BOOT_CHECKSUM_EN
                sum      <= sum + word;
`endif
            end
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Randomized bench for boot_sequencer against a stream-level reference model.
// Honors BOOT_CHECKSUM_EN the same way the design does.
module tb_boot_sequencer;

    localparam int MW = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        cpu_reset;
    logic [29:0] cpu_bus_addr = 30'd0;
    logic [31:0] cpu_bus_data_w = 32'd0;
    logic [3:0]  cpu_bus_mask_w = 4'd0;
    logic [29:0] mem_addr;
    logic [31:0] mem_data_w;
    logic [3:0]  mem_mask_w;
    logic        busy;
    logic        error;

    boot_sequencer #(.MAX_WORDS(MW)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .cpu_reset(cpu_reset),
        .cpu_bus_addr(cpu_bus_addr),
        .cpu_bus_data_w(cpu_bus_data_w),
        .cpu_bus_mask_w(cpu_bus_mask_w),
        .mem_addr(mem_addr),
        .mem_data_w(mem_data_w),
        .mem_mask_w(mem_mask_w),
        .busy(busy),
        .error(error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        int          cyc;
    } wr_t;

    wr_t         wr_q[$];
    logic [7:0]  sq[$];
    logic [31:0] wq[$];
    int          cyc = 0;
    int          last_acc = 0;
    int          run_cyc = 0;
    bit          cpu_rand = 1'b1;

    // Loader-phase writes and the first released cycle, seen mid-cycle.
    always @(negedge clock) begin
        cyc++;
        if (in_valid && in_ready)
            last_acc = cyc;
        if (cpu_reset && mem_mask_w != 4'h0)
            wr_q.push_back('{mem_addr, mem_data_w, mem_mask_w, cyc});
        if (!cpu_reset && run_cyc == 0)
            run_cyc = cyc;
    end

    always @(posedge clock) begin
        if (cpu_rand) begin
            #1;
            cpu_bus_addr   = 30'($urandom);
            cpu_bus_data_w = $urandom;
            cpu_bus_mask_w = 4'($urandom);
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        wr_q.delete();
        run_cyc = 0;
        last_acc = 0;
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 1);
        check("rst_error", error, 0);
        check("rst_mask", mem_mask_w, 0);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            sq.push_back(w[8*i +: 8]);
    endtask

    task automatic drive_byte(input logic [7:0] b, input int gap);
        int g = 0;
        while (g < 8 && int'($urandom_range(99)) < gap) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            @(posedge clock);
            #1;
            g++;
        end
        in_valid = 1'b1;
        in_data = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_case(input string tag, input int gap,
                            input bit hdr_bad, input bit trl_bad);
        logic [31:0] sum;
        bit          exp_err;
        int          nexp;
        int          n;
        int          t;
        do_reset();
        sq.delete();
        push_word(hdr_bad ? 32'(MW + 1) : 32'(wq.size()));
        sum = 32'd0;
        if (!hdr_bad) begin
            foreach (wq[i]) begin
                push_word(wq[i]);
                sum += wq[i];
            end
`ifdef BOOT_CHECKSUM_EN
            push_word(trl_bad ? (sum ^ 32'd1) : sum);
`endif
        end
        exp_err = hdr_bad || trl_bad;
        foreach (sq[i])
            drive_byte(sq[i], gap);
        t = 0;
        do begin
            @(negedge clock);
            #1;
            t++;
        end while (busy && t < 40);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_error"}, error, 64'(exp_err));
        check({tag, "_cpu_reset"}, cpu_reset, 64'(exp_err));
        check({tag, "_in_ready"}, in_ready, 0);
        nexp = hdr_bad ? 0 : wq.size();
        check({tag, "_nwr"}, wr_q.size(), nexp);
        n = (wr_q.size() < nexp) ? wr_q.size() : nexp;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, i);
            check($sformatf("%s_data%0d", tag, i), wr_q[i].data, wq[i]);
            check($sformatf("%s_mask%0d", tag, i), wr_q[i].mask, 4'hF);
        end
        if (exp_err) begin
            check({tag, "_norun"}, run_cyc, 0);
        end else begin
`ifdef BOOT_CHECKSUM_EN
            check({tag, "_run_at"}, run_cyc, last_acc + 1);
`else
            if (nexp == 0) begin
                check({tag, "_run_at"}, run_cyc, last_acc + 1);
            end else if (wr_q.size() > 0) begin
                check({tag, "_wr_at"}, wr_q[wr_q.size()-1].cyc,
                      last_acc + 1);
                check({tag, "_run_at"}, run_cyc,
                      wr_q[wr_q.size()-1].cyc + 1);
            end
`endif
        end
    endtask

    initial begin
        wq = {32'h0000_0013, 32'hDEAD_BEEF};
        run_case("two", 0, 0, 0);

        cpu_rand = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_bus_addr   = 30'($urandom);
            cpu_bus_data_w = $urandom;
            cpu_bus_mask_w = 4'($urandom);
            #1;
            check("pass_addr", mem_addr, cpu_bus_addr);
            check("pass_data", mem_data_w, cpu_bus_data_w);
            check("pass_mask", mem_mask_w, cpu_bus_mask_w);
        end
        cpu_rand = 1'b1;

        wq.delete();
        run_case("empty", 0, 0, 0);

        run_case("toolong", 0, 1, 0);

        wq = {32'h0000_0013, 32'hDEAD_BEEF};
        for (int k = 0; k < 3; k++)
            run_case($sformatf("gaps%0d", k), 50, 0, 0);

`ifdef BOOT_CHECKSUM_EN
        run_case("badsum", 0, 0, 1);
`endif

        do_reset();
        sq.delete();
        push_word(32'd2);
        push_word(32'hA5A5_5A5A);
        for (int i = 0; i < 2; i++)
            drive_byte(sq[i + 4], 0);
        for (int i = 0; i < 4; i++)
            drive_byte(sq[i], 0);
        check("mid_nwr", wr_q.size(), 0);
        wq = {32'h1234_5678};
        run_case("restart", 0, 0, 0);

        for (int k = 0; k < 10; k++) begin
            int n;
            n = (k == 0) ? MW : int'($urandom_range(MW, 1));
            wq.delete();
            for (int i = 0; i < n; i++)
                wq.push_back($urandom);
            run_case($sformatf("rnd%0d", k),
                     int'($urandom_range(60)), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
